// File: rtl/pic16f84_x1_fetch_if.sv
// Program-ROM fetch bus between the PIC16F84 fetch sequencer (master)
// and the ROM/execute side (slave).
interface pic16f84_x1_fetch_if #(
  parameter int PC_WIDTH   = 13,
  parameter int INST_WIDTH = 14
);
  logic [INST_WIDTH-1:0] inst_in;
  logic                  stall;
  logic                  branch_en;
  logic                  call_en;
  logic                  return_en;
  logic [PC_WIDTH-1:0]   target_in;
  logic                  q1, q2, q3, q4;
  logic [PC_WIDTH-1:0]   pc_out;
  logic [INST_WIDTH-1:0] ir_out;
  logic                  ir_valid;
  logic                  nop_out;
  logic                  stack_overflow;
  logic                  stack_underflow;

  modport master (
    input  inst_in, stall, branch_en, call_en, return_en, target_in,
    output q1, q2, q3, q4, pc_out, ir_out, ir_valid, nop_out,
           stack_overflow, stack_underflow
  );

  modport slave (
    output inst_in, stall, branch_en, call_en, return_en, target_in,
    input  q1, q2, q3, q4, pc_out, ir_out, ir_valid, nop_out,
           stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pic16f84_x1_fetch.sv
// PIC16F84 instruction-fetch sequencer: Q1..Q4 phase generator, PC/IR
// pipeline with redirect flush, and a circular hardware return stack.
module pic16f84_x1_fetch #(
  parameter int                    PC_WIDTH     = 13,
  parameter int                    INST_WIDTH   = 14,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = 13'h0000,
  parameter int                    STACK_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  pic16f84_x1_fetch_if.master       bus
);
  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W:0] DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);

  localparam logic [1:0] PH_Q1 = 2'd0;
  localparam logic [1:0] PH_Q2 = 2'd1;
  localparam logic [1:0] PH_Q3 = 2'd2;
  localparam logic [1:0] PH_Q4 = 2'd3;

  logic [1:0]            phase_q;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] ir_q, ir_d;
  logic                  vld_q, vld_d;
  logic                  nop_q, nop_d;
  logic [SP_W-1:0]       sp_q, sp_d, sp_dec;
  logic [SP_W:0]         dep_q, dep_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push;
  logic                  eoc;
  logic [PC_WIDTH-1:0]   stack_q [STACK_DEPTH];

  assign eoc    = (phase_q == PH_Q4);
  assign sp_dec = sp_q - SP_W'(1);

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    vld_d = vld_q;
    nop_d = nop_q;
    sp_d  = sp_q;
    dep_d = dep_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (eoc) begin
      if (bus.return_en) begin
        // Empty-stack pop still reads the wrapped slot; only the flag records it.
        pc_d = stack_q[sp_dec];
        sp_d = sp_dec;
        if (dep_q == '0) unf_d = 1'b1;
        else             dep_d = dep_q - (SP_W+1)'(1);
      end else if (bus.call_en) begin
        push = 1'b1;
        pc_d = bus.target_in;
        sp_d = sp_q + SP_W'(1);
        if (dep_q == DEPTH_FULL) ovf_d = 1'b1;
        else                     dep_d = dep_q + (SP_W+1)'(1);
      end else if (bus.branch_en) begin
        pc_d = bus.target_in;
      end
      if (bus.return_en || bus.call_en || bus.branch_en) begin
        ir_d  = '0;
        vld_d = 1'b0;
        nop_d = 1'b1;
      end else if (bus.stall) begin
        vld_d = 1'b0;
        nop_d = 1'b0;
      end else begin
        ir_d  = bus.inst_in;
        vld_d = 1'b1;
        nop_d = 1'b0;
        pc_d  = pc_q + PC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_Q1;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      vld_q   <= 1'b0;
      nop_q   <= 1'b1;
      sp_q    <= '0;
      dep_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      phase_q <= phase_q + 2'd1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
      nop_q   <= nop_d;
      sp_q    <= sp_d;
      dep_q   <= dep_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      // A full stack's write slot is the oldest entry, so overflow overwrites it.
      if (push) stack_q[sp_q] <= pc_q;
    end
  end

  assign bus.q1              = (phase_q == PH_Q1);
  assign bus.q2              = (phase_q == PH_Q2);
  assign bus.q3              = (phase_q == PH_Q3);
  assign bus.q4              = (phase_q == PH_Q4);
  assign bus.pc_out          = pc_q;
  assign bus.ir_out          = ir_q;
  assign bus.ir_valid        = vld_q;
  assign bus.nop_out         = nop_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_pic16f84_x1_fetch.sv
// Directed bench for pic16f84_x1_fetch: phases, PC/IR pipeline, redirects,
// return stack overflow/underflow, wrap and async reset.
module tb_pic16f84_x1_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  pic16f84_x1_fetch_if #(.PC_WIDTH(13), .INST_WIDTH(14)) bus ();

  pic16f84_x1_fetch #(
    .PC_WIDTH(13), .INST_WIDTH(14), .RESET_VECTOR(13'h0000), .STACK_DEPTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_ctl();
    bus.stall = 1'b0; bus.branch_en = 1'b0; bus.call_en = 1'b0;
    bus.return_en = 1'b0; bus.target_in = '0;
  endtask

  // Drive controls during Q4, cross the end-of-cycle edge, land in Q1.
  task automatic run_cycle(input logic st, input logic br, input logic ca,
                           input logic re, input logic [12:0] tgt,
                           input logic [13:0] inst);
    int n = 0;
    while (!bus.q4 && n < 8) begin @(negedge clk); n++; end
    if (n >= 8) chk("q4_timeout", 32'(n), 32'd0);
    bus.stall = st; bus.branch_en = br; bus.call_en = ca;
    bus.return_en = re; bus.target_in = tgt; bus.inst_in = inst;
    @(posedge clk); #1;
    clr_ctl();
  endtask

  task automatic chk_slot(input string tag, input logic [12:0] pc,
                          input logic [13:0] ir, input logic vld, input logic nop);
    chk({tag, "_pc"},  32'(bus.pc_out),   32'(pc));
    chk({tag, "_ir"},  32'(bus.ir_out),   32'(ir));
    chk({tag, "_vld"}, 32'(bus.ir_valid), 32'(vld));
    chk({tag, "_nop"}, 32'(bus.nop_out),  32'(nop));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_q"}, 32'({bus.q1, bus.q2, bus.q3, bus.q4}), 32'b1000);
    chk_slot(tag, 13'h0000, 14'h0000, 1'b0, 1'b1);
    chk({tag, "_ovf"}, 32'(bus.stack_overflow),  32'd0);
    chk({tag, "_unf"}, 32'(bus.stack_underflow), 32'd0);
  endtask

  initial begin
    logic [3:0] qexp;
    bus.inst_in = 14'h1234;
    clr_ctl();
    #12;
    chk_reset("rst0");
    @(negedge clk); rst = 1'b0; #1;

    // Phase rotation through the first cycle
    qexp = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("phase%0d", i), 32'({bus.q1, bus.q2, bus.q3, bus.q4}), 32'(qexp));
      if (i < 3) chk($sformatf("first_nop%0d", i), 32'({bus.ir_valid, bus.nop_out}), 32'b01);
      qexp = qexp >> 1;
      @(posedge clk); #1;
    end
    chk_slot("run1", 13'h0001, 14'h1234, 1'b1, 1'b0);
    chk("phase_wrap", 32'({bus.q1, bus.q2, bus.q3, bus.q4}), 32'b1000);

    run_cycle(0, 0, 0, 0, 13'h0, 14'h0AAA); chk_slot("run2", 13'h0002, 14'h0AAA, 1, 0);
    run_cycle(0, 0, 0, 0, 13'h0, 14'h0BBB); chk_slot("run3", 13'h0003, 14'h0BBB, 1, 0);
    run_cycle(0, 0, 0, 0, 13'h0, 14'h0CCC);
    run_cycle(0, 0, 0, 0, 13'h0, 14'h0DDD); chk_slot("run5", 13'h0005, 14'h0DDD, 1, 0);

    // Branch with flush
    run_cycle(0, 1, 0, 0, 13'h03FE, 14'h3FFF); chk_slot("br", 13'h03FE, 14'h0000, 0, 1);
    run_cycle(0, 0, 0, 0, 13'h0, 14'h1111);    chk_slot("br_after", 13'h03FF, 14'h1111, 1, 0);

    // Two stalled cycles
    run_cycle(1, 0, 0, 0, 13'h0, 14'h2222); chk_slot("stall1", 13'h03FF, 14'h1111, 0, 0);
    @(posedge clk); #1;
    chk("stall_q2", 32'({bus.q1, bus.q2, bus.q3, bus.q4}), 32'b0100);
    run_cycle(1, 0, 0, 0, 13'h0, 14'h2222); chk_slot("stall2", 13'h03FF, 14'h1111, 0, 0);
    run_cycle(0, 0, 0, 0, 13'h0, 14'h2222); chk_slot("unstall", 13'h0400, 14'h2222, 1, 0);

    // Branch request outside Q4 is ignored
    @(posedge clk); #1;
    bus.branch_en = 1'b1; bus.target_in = 13'h1ABC;
    @(posedge clk); #1;
    clr_ctl();
    run_cycle(0, 0, 0, 0, 13'h0, 14'h0123); chk_slot("midq_ign", 13'h0401, 14'h0123, 1, 0);

    // Stall together with branch: branch wins
    run_cycle(1, 1, 0, 0, 13'h0010, 14'h3333); chk_slot("stall_br", 13'h0010, 14'h0000, 0, 1);

    // Call / return
    run_cycle(0, 0, 1, 0, 13'h0400, 14'h3333); chk_slot("call", 13'h0400, 14'h0000, 0, 1);
    run_cycle(0, 0, 0, 0, 13'h0, 14'h0055);    chk_slot("call_run", 13'h0401, 14'h0055, 1, 0);
    run_cycle(0, 0, 0, 0, 13'h0, 14'h0066);
    run_cycle(0, 0, 0, 1, 13'h0, 14'h0077);    chk_slot("ret", 13'h0010, 14'h0000, 0, 1);
    chk("cr_flags", 32'({bus.stack_overflow, bus.stack_underflow}), 32'b00);

    // Return + call together: pop only
    run_cycle(0, 0, 1, 0, 13'h0700, 14'h0);
    run_cycle(0, 0, 1, 0, 13'h0900, 14'h0);
    run_cycle(0, 0, 1, 1, 13'h0ABC, 14'h0); chk("retcall_pc", 32'(bus.pc_out), 32'h0700);
    run_cycle(0, 0, 0, 1, 13'h0, 14'h0);    chk("retcall_pc2", 32'(bus.pc_out), 32'h0010);
    chk("retcall_flags", 32'({bus.stack_overflow, bus.stack_underflow}), 32'b00);

    // PC wrap
    run_cycle(0, 1, 0, 0, 13'h1FFF, 14'h0); chk("wrap_pre", 32'(bus.pc_out), 32'h1FFF);
    run_cycle(0, 0, 0, 0, 13'h0, 14'h0777); chk_slot("wrap", 13'h0000, 14'h0777, 1, 0);

    // Nine nested calls then nine returns
    for (int k = 1; k <= 9; k++) begin
      run_cycle(0, 0, 1, 0, 13'(k * 'h100), 14'h0);
      if (k == 8) chk("ovf_at8", 32'(bus.stack_overflow), 32'd0);
    end
    chk("ovf_at9", 32'(bus.stack_overflow), 32'd1);
    chk("ovf_pc", 32'(bus.pc_out), 32'h0900);
    for (int r = 1; r <= 9; r++) begin
      run_cycle(0, 0, 0, 1, 13'h0, 14'h0);
      chk($sformatf("pop%0d", r), 32'(bus.pc_out), (r == 9) ? 32'h0800 : 32'(('h100 * (9 - r))));
      if (r == 8) chk("unf_at8", 32'(bus.stack_underflow), 32'd0);
    end
    chk("unf_at9", 32'(bus.stack_underflow), 32'd1);

    // Async reset asserted in Q3
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_q3", 32'(bus.q3), 32'd1);
    #2 rst = 1'b1; #1;
    chk_reset("arst");

    // Fresh reset, then an immediate return underflows
    @(negedge clk); rst = 1'b0; #1;
    run_cycle(0, 0, 0, 1, 13'h0, 14'h0);
    chk("unf_fresh", 32'(bus.stack_underflow), 32'd1);
    chk("unf_fresh_ovf", 32'(bus.stack_overflow), 32'd0);
    chk_slot("unf_fresh", 13'h0000, 14'h0000, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
